// File: rtl/prog_mem_responder.sv
// Round-robin read responder: serves NUM_CONSUMERS held-valid fetchers from one upstream program-memory port.
// Optional one-entry last-word cache enabled by defining PROG_MEM_LAST_WORD_CACHE_EN.
module prog_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    busy
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RESPOND  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  state_e                                 state_q, state_d;
  logic [PTR_W-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                       grant_q, grant_d;
  logic [NUM_CONSUMERS-1:0]               ready_q, ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q, data_d;
  logic                                   mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]                   mem_addr_q, mem_addr_d;

  logic                                   req_found;
  logic [PTR_W-1:0]                       req_pick;
  logic [PTR_W-1:0]                       req_next_ptr;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    req_found = 1'b0;
    req_pick  = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_CONSUMERS;
      if (!req_found && consumer_read_valid[idx[PTR_W-1:0]]) begin
        req_found = 1'b1;
        req_pick  = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    if (req_pick == PTR_W'(NUM_CONSUMERS - 1)) begin
      req_next_ptr = '0;
    end else begin
      req_next_ptr = req_pick + 1'b1;
    end
  end

`ifdef PROG_MEM_LAST_WORD_CACHE_EN
  logic                 cache_valid_q, cache_valid_d;
  logic [ADDR_BITS-1:0] cache_addr_q, cache_addr_d;
  logic [DATA_BITS-1:0] cache_data_q, cache_data_d;
  logic                 cache_hit;

  assign cache_hit = cache_valid_q && (cache_addr_q == consumer_read_address[req_pick]);

  // Every upstream completion refreshes the single cached (address, data) pair.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    if (state_q == WAIT_MEM && mem_read_ready) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = mem_addr_q;
      cache_data_d  = mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
    end
  end
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    ready_d     = '0;
    data_d      = data_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;

    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d  = req_pick;
          rr_ptr_d = req_next_ptr;
`ifdef PROG_MEM_LAST_WORD_CACHE_EN
          if (cache_hit) begin
            data_d[req_pick]  = cache_data_q;
            ready_d[req_pick] = 1'b1;
            state_d           = RESPOND;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = consumer_read_address[req_pick];
            state_d     = WAIT_MEM;
          end
`else
          mem_valid_d = 1'b1;
          mem_addr_d  = consumer_read_address[req_pick];
          state_d     = WAIT_MEM;
`endif
        end
      end

      WAIT_MEM: begin
        if (mem_read_ready) begin
          data_d[grant_q]  = mem_read_data;
          ready_d[grant_q] = 1'b1;
          mem_valid_d      = 1'b0;
          state_d          = RESPOND;
        end
      end

      // ready_d defaults to zero, which ends the one-cycle pulse here.
      RESPOND: begin
        state_d = RELEASE;
      end

      // Hold off re-arbitration until the served consumer has dropped valid.
      RELEASE: begin
        if (!consumer_read_valid[grant_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the returned-word registers are ordinary flops, so they take a reset value like all other state.
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      ready_q     <= '0;
      data_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign consumer_read_ready = ready_q;
  assign consumer_read_data  = data_q;
  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed self-checking bench for prog_mem_responder (default parameters).
// Define PROG_MEM_LAST_WORD_CACHE_EN to exercise the last-word cache path.
module tb_prog_mem_responder;

  logic            clk;
  logic            reset;
  logic [3:0]      consumer_read_valid;
  logic [3:0][7:0] consumer_read_address;
  logic [3:0]      consumer_read_ready;
  logic [3:0][15:0] consumer_read_data;
  logic            mem_read_valid;
  logic [7:0]      mem_read_address;
  logic            mem_read_ready;
  logic [15:0]     mem_read_data;
  logic            busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  prog_mem_responder dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Serve one upstream transaction for consumer g, acting as memory and as a fetcher that drops valid on ready.
  task automatic serve(input string tag, input int g, input logic [7:0] addr, input logic [15:0] word);
    int n;
    logic [3:0] onehot;
    n = 0;
    onehot = 4'b0001 << g;
    while (!mem_read_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_req"}, mem_read_valid, 1);
    check({tag, "_addr"}, mem_read_address, addr);
    check({tag, "_busy"}, busy, 1);
    mem_read_ready = 1'b1;
    mem_read_data  = word;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h5A5A;
    check({tag, "_ready"}, consumer_read_ready, onehot);
    check({tag, "_data"}, consumer_read_data[g], word);
    check({tag, "_memv_low"}, mem_read_valid, 0);
    consumer_read_valid[g] = 1'b0;
    tick();
    check({tag, "_ready_clr"}, consumer_read_ready, 0);
  endtask

  initial begin
    reset                 = 1'b1;
    consumer_read_valid   = '0;
    consumer_read_address = '0;
    mem_read_ready        = 1'b0;
    mem_read_data         = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_memv", mem_read_valid, 0);
    check("rst_addr", mem_read_address, 0);
    check("rst_ready", consumer_read_ready, 0);
    check("rst_data", consumer_read_data, 0);

    // mem_read_ready outside WAIT_MEM is ignored
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    tick();
    mem_read_ready = 1'b0;
    check("idle_ign_ready", consumer_read_ready, 0);
    check("idle_ign_data", consumer_read_data, 0);

    // Single request: consumer 1, address 0x12, word 0xBEEF
    consumer_read_valid[1]   = 1'b1;
    consumer_read_address[1] = 8'h12;
    tick();
    check("single_memv", mem_read_valid, 1);
    check("single_addr", mem_read_address, 8'h12);
    check("single_no_ready", consumer_read_ready, 0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    check("single_ready", consumer_read_ready, 4'b0010);
    check("single_data", consumer_read_data[1], 16'hBEEF);
    consumer_read_valid[1] = 1'b0;
    tick();
    check("single_pulse_1cyc", consumer_read_ready, 0);
    check("single_busy_release", busy, 1);
    tick();
    check("single_idle", busy, 0);
    check("single_data_held", consumer_read_data[1], 16'hBEEF);
    check("single_other_data", consumer_read_data[0], 0);

    // Simultaneous requests from 0, 2, 3 right after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sim_rst_data", consumer_read_data, 0);
    consumer_read_valid      = 4'b1101;
    consumer_read_address[0] = 8'h30;
    consumer_read_address[2] = 8'h32;
    consumer_read_address[3] = 8'h33;
    tick();
    serve("sim_g0", 0, 8'h30, 16'h1000);
    serve("sim_g2", 2, 8'h32, 16'h2002);
    serve("sim_g3", 3, 8'h33, 16'h3003);
    check("sim_data0_held", consumer_read_data[0], 16'h1000);
    tick();

    // Round-robin: consumer 0 re-requests while consumer 3 waits
    reset = 1'b1;
    tick();
    reset = 1'b0;
    consumer_read_valid      = 4'b1001;
    consumer_read_address[0] = 8'h40;
    consumer_read_address[3] = 8'h43;
    tick();
    serve("rr_g0", 0, 8'h40, 16'h4000);
    tick();
    consumer_read_valid[0] = 1'b1;
    serve("rr_g3_first", 3, 8'h43, 16'h4343);
    serve("rr_g0_again", 0, 8'h40, 16'h4001);
    tick();

    // Upstream stall of 5 cycles on consumer 2
    consumer_read_valid[2]   = 1'b1;
    consumer_read_address[2] = 8'h55;
    tick();
    check("stall_memv_0", mem_read_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_memv", mem_read_valid, 1);
      check("stall_addr", mem_read_address, 8'h55);
      check("stall_busy", busy, 1);
      check("stall_no_ready", consumer_read_ready, 0);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hCAFE;
    tick();
    mem_read_ready = 1'b0;
    check("stall_ready", consumer_read_ready, 4'b0100);
    check("stall_data", consumer_read_data[2], 16'hCAFE);
    consumer_read_valid[2] = 1'b0;
    tick();
    tick();
    check("stall_idle", busy, 0);

    // Reset in WAIT_MEM, with a completion offered on the reset edge
    consumer_read_valid[1]   = 1'b1;
    consumer_read_address[1] = 8'h66;
    tick();
    check("rstmid_memv_pre", mem_read_valid, 1);
    reset          = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h7777;
    tick();
    check("rstmid_memv", mem_read_valid, 0);
    check("rstmid_ready", consumer_read_ready, 0);
    check("rstmid_data", consumer_read_data, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_addr", mem_read_address, 0);
    reset                  = 1'b0;
    mem_read_ready         = 1'b0;
    consumer_read_valid[1] = 1'b0;
    tick();
    check("rstmid_no_pulse", consumer_read_ready, 0);

    // Repeat fetch of one address: cache hit when enabled, upstream otherwise
    consumer_read_valid[0]   = 1'b1;
    consumer_read_address[0] = 8'h20;
    tick();
    serve("c_first", 0, 8'h20, 16'h1234);
    tick();
    consumer_read_valid[1]   = 1'b1;
    consumer_read_address[1] = 8'h20;
    tick();
`ifdef PROG_MEM_LAST_WORD_CACHE_EN
    check("cache_hit_ready", consumer_read_ready, 4'b0010);
    check("cache_hit_data", consumer_read_data[1], 16'h1234);
    check("cache_hit_no_memv", mem_read_valid, 0);
    consumer_read_valid[1] = 1'b0;
    tick();
    check("cache_hit_memv_still_low", mem_read_valid, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    consumer_read_valid[0]   = 1'b1;
    consumer_read_address[0] = 8'h20;
    tick();
    check("cache_after_rst_memv", mem_read_valid, 1);
    serve("cache_after_rst", 0, 8'h20, 16'h4321);
`else
    check("nocache_memv", mem_read_valid, 1);
    check("nocache_no_ready", consumer_read_ready, 0);
    serve("nocache_second", 1, 8'h20, 16'h1235);
`endif
    tick();
    tick();
    check("final_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
